// File: rtl/axi4_stream_writer_v2.sv
// AXI4-Stream master fed by a valid/ready user port through a 2-entry FIFO.
// Beats are grouped into packets of pkt_len words; TLAST and pkt_done mark packet ends.
module axi4_stream_writer_v2 #(
   parameter int C_M_AXIS_TDATA_WIDTH = 32,
   parameter int C_PKT_LEN_WIDTH      = 16
) (
   input  logic                                M_AXIS_ACLK,
   input  logic                                M_AXIS_ARESET,
   output logic                                M_AXIS_TVALID,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
   output logic                                M_AXIS_TLAST,
   input  logic                                M_AXIS_TREADY,
   input  logic                                data_valid,
   input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     data,
   output logic                                ready,
   input  logic [C_PKT_LEN_WIDTH-1:0]          pkt_len,
   output logic                                pkt_done
);

   localparam int DW = C_M_AXIS_TDATA_WIDTH;
   localparam int LW = C_PKT_LEN_WIDTH;
   localparam logic [LW-1:0] LEN_ONE = LW'(1);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_e;

   occ_e            state_q, state_d;
   logic [DW-1:0]   head_data_q, head_data_d;
   logic [DW-1:0]   tail_data_q, tail_data_d;
   logic            head_last_q, head_last_d;
   logic            tail_last_q, tail_last_d;
   logic            ready_q, ready_d;
   logic            done_q, done_d;
   logic [LW-1:0]   cnt_q, cnt_d;
   logic [LW-1:0]   len_q, len_d;
   logic [LW-1:0]   len_eff;
   logic            in_last;
   logic            accept;
   logic            xfer;

   assign M_AXIS_TVALID = (state_q != EMPTY);
   assign M_AXIS_TDATA  = head_data_q;
   assign M_AXIS_TLAST  = head_last_q;
   assign M_AXIS_TSTRB  = '1;
   assign ready         = ready_q;
   assign pkt_done      = done_q;

   assign accept = data_valid & ready_q;
   assign xfer   = M_AXIS_TVALID & M_AXIS_TREADY;

   // Packet tagging: the first beat uses the live pkt_len so a 1-beat packet is tagged at once.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      len_eff = len_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      if (cnt_q == '0) begin
         len_eff = (pkt_len == '0) ? LEN_ONE : pkt_len;
      end
      in_last = (cnt_q == (len_eff - LEN_ONE));
      if (accept) begin
         len_d = len_eff;
         cnt_d = in_last ? '0 : (cnt_q + LEN_ONE);
      end
   end

   always_comb begin
      state_d     = state_q;
      head_data_d = head_data_q;
      head_last_d = head_last_q;
      tail_data_d = tail_data_q;
      tail_last_d = tail_last_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               head_data_d = data;
               head_last_d = in_last;
               state_d     = ONE;
            end
         end
         ONE: begin
            unique case ({accept, xfer})
               2'b11: begin
                  head_data_d = data;
                  head_last_d = in_last;
               end
               2'b10: begin
                  tail_data_d = data;
                  tail_last_d = in_last;
                  state_d     = FULL;
               end
               2'b01:   state_d = EMPTY;
               default: state_d = ONE;
            endcase
         end
         FULL: begin
            // ready is low here, so only a drain can happen
            if (xfer) begin
               head_data_d = tail_data_q;
               head_last_d = tail_last_q;
               state_d     = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      ready_d = (state_d != FULL);
      done_d  = xfer & head_last_q;
   end

   always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
      if (M_AXIS_ARESET) begin
         state_q     <= EMPTY;
         head_data_q <= '0;
         head_last_q <= 1'b0;
         tail_data_q <= '0;
         tail_last_q <= 1'b0;
         ready_q     <= 1'b0;
         done_q      <= 1'b0;
         cnt_q       <= '0;
         len_q       <= LEN_ONE;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q     <= state_d;
         head_data_q <= head_data_d;
         head_last_q <= head_last_d;
         tail_data_q <= tail_data_d;
         tail_last_q <= tail_last_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
      end
   end

endmodule

// File: doc/axi4_stream_writer_v2.md
AXI4_STREAM_WRITER_V2 -- requirements
Module: axi4_stream_writer_v2

Interface
REQ-001 Parameter C_M_AXIS_TDATA_WIDTH, default 32, SHALL set the TDATA width in bits; legal values are multiples of 8.
REQ-002 Parameter C_PKT_LEN_WIDTH, default 16, SHALL set the width of the packet-length input and the beat counter.
REQ-003 M_AXIS_ACLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 M_AXIS_ARESET  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 M_AXIS_TVALID  output  1  SHALL be the AXI4-Stream valid.
REQ-006 M_AXIS_TDATA  output  C_M_AXIS_TDATA_WIDTH  SHALL be the AXI4-Stream data.
REQ-007 M_AXIS_TSTRB  output  C_M_AXIS_TDATA_WIDTH/8  SHALL be the byte strobe, driven all-ones.
REQ-008 M_AXIS_TLAST  output  1  SHALL mark the final beat of a packet.
REQ-009 M_AXIS_TREADY  input  1  SHALL be the downstream ready.
REQ-010 data_valid  input  1  SHALL indicate that the user offers a word on data.
REQ-011 data  input  C_M_AXIS_TDATA_WIDTH  SHALL be the user word.
REQ-012 ready  output  1  SHALL indicate that the block accepts the user word this cycle.
REQ-013 pkt_len  input  C_PKT_LEN_WIDTH  SHALL be the packet length in beats; it is sampled on the first beat of each packet.
REQ-014 pkt_done  output  1  SHALL be a one-cycle pulse on the cycle the TLAST beat transfers on the AXI side.

Function
REQ-015 User accept SHALL occur when data_valid=1 and ready=1. AXI transfer SHALL occur when M_AXIS_TVALID=1 and M_AXIS_TREADY=1.
REQ-016 The block SHALL contain a 2-entry FIFO. Each entry holds {data, last}.
REQ-017 The FIFO occupancy states SHALL be EMPTY(0), ONE(1) and FULL(2).
REQ-018 ready SHALL be a registered output equal to 1 when the FIFO is not FULL after the current edge, so it never combinationally depends on M_AXIS_TREADY.
REQ-019 The FIFO SHALL change state as follows:
- accept only: occupancy +1.
- transfer only: occupancy -1.
- both in the same cycle: occupancy unchanged and order preserved.
REQ-020 Accept in FULL SHALL be impossible, because ready=0 in FULL.
REQ-021 Transfer in EMPTY SHALL be impossible, because TVALID=0 in EMPTY.
REQ-022 M_AXIS_TVALID SHALL be 1 exactly when occupancy>0. TDATA/TLAST SHALL present the head entry.
REQ-023 Latency: a word accepted at edge N SHALL appear on TDATA with TVALID=1 from cycle N+1 when the FIFO was EMPTY.
REQ-024 Once TVALID=1, TDATA/TLAST/TVALID SHALL remain stable until transfer (AXI rule).
REQ-025 The beat counter SHALL count accepted user words within the current packet, starting from 0.
REQ-026 On an accept with counter=0, the block SHALL latch pkt_len into a length register L. A pkt_len of 0 SHALL be latched as 1.
REQ-027 The accepted word SHALL be tagged last=1 when counter = L-1, using the freshly latched L on the first beat. The counter SHALL then wrap to 0; otherwise it increments.
REQ-028 With L=1, every beat SHALL carry TLAST=1.
REQ-029 A change of pkt_len mid-packet SHALL have no effect until the next first beat.
REQ-030 The counter SHALL use C_PKT_LEN_WIDTH bits. L = 2^C_PKT_LEN_WIDTH-1 SHALL be supported without overflow.
REQ-031 pkt_done SHALL be registered and assert the cycle after the TLAST transfer edge for one cycle.

Reset
REQ-032 On M_AXIS_ARESET=1, the block SHALL asynchronously clear:
- FIFO to EMPTY;
- M_AXIS_TVALID=0 and M_AXIS_TLAST=0;
- M_AXIS_TDATA=0;
- ready=0;
- beat counter=0, L=1;
- pkt_done=0.
REQ-033 ready SHALL become 1 at the first clock edge after reset deasserts.
REQ-034 Reset mid-packet SHALL discard buffered words and the partial count; the next accepted word is a first beat.

Verification
REQ-035 pkt_len=4, data_valid held 1, TREADY held 1, data 0x10..0x17 -> TDATA 0x10..0x17 on consecutive cycles, TLAST on 0x13 and 0x17, two pkt_done pulses.
REQ-036 TREADY=0 while pushing 0xA,0xB,0xC -> ready drops to 0 after 0xA,0xB are accepted; 0xC is held off. TREADY=1 -> order 0xA,0xB,0xC with no loss and no duplicate.
REQ-037 pkt_len=0 -> every beat has TLAST=1 and every transfer gives a pkt_done pulse.
REQ-038 pkt_len changes from 3 to 5 after beat 1 of a packet -> that packet still ends at beat 3 and the next packet ends at beat 5.
REQ-039 Reset asserted with 2 words buffered and counter=2 -> TVALID=0 immediately (async). After release, the next packet of pkt_len=2 ends TLAST at its 2nd word.
REQ-040 Random TREADY/data_valid with pkt_len=7 over 1000 words -> scoreboard matches data and TLAST positions, and TDATA is stable while TVALID=1 and TREADY=0.
